pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline. Drives the write-enables, bubbles
//  and flushes of the IF/ID, ID/EX and EX/MEM registers, the EX-stage forwarding muxes, and a

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls, EX redirects,
// multi-cycle MUL/DIV stall sequencing, EX operand forwarding and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_mdu_op,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MCNT_W = $clog2(MDU_LAT + 1);
    localparam logic [MCNT_W-1:0] MDU_LOAD = MCNT_W'(MDU_LAT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [MCNT_W-1:0] mdu_cnt;
    logic              load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // MEM result is newer than WB, so it wins; x0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b10;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_bubble = 1'b0;
        fwd_a         = 2'b00;
        fwd_b         = 2'b00;
        mdu_done      = 1'b0;
        if (rst) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            fwd_a       = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            fwd_b       = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            // While the MDU sequence runs, every other hazard source is ignored.
            if (state == MDU_BUSY) begin
                if (mdu_cnt != '0) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                end else begin
                    mdu_done = 1'b1;
                end
            end else if (ex_mdu_op) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_hold    = 1'b1;
                ex_mem_bubble = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // The exit cycle returns straight to RUN so the finished op in EX cannot retrigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            mdu_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (!pc_write)
                stall_cnt <= sat_inc(stall_cnt);
            case (state)
                RUN: begin
                    if (ex_mdu_op) begin
                        state   <= MDU_BUSY;
                        mdu_cnt <= MDU_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt != '0)
                        mdu_cnt <= mdu_cnt - MCNT_W'(1);
                    else
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed MDU/reset/saturation sequences, and
// randomized cycles checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_W2  = 2;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_mdu_op;
    logic mem_reg_write, wb_reg_write;

    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mdu_done;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, id_ex_hold2, ex_mem_bubble2, mdu_done2;
    logic [1:0] fwd_a2, fwd_b2;
    logic [CNT_W2-1:0] stall_cnt2;

    logic [10:0] out1, out2;
    assign out1 = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble,
                   fwd_a, fwd_b, mdu_done};
    assign out2 = {pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, id_ex_hold2, ex_mem_bubble2,
                   fwd_a2, fwd_b2, mdu_done2};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .ex_mdu_op(ex_mdu_op), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .ex_mdu_op(ex_mdu_op), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_write(pc_write2), .if_id_write(if_id_write2), .if_id_flush(if_id_flush2),
        .id_ex_bubble(id_ex_bubble2), .id_ex_hold(id_ex_hold2), .ex_mem_bubble(ex_mem_bubble2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .mdu_done(mdu_done2), .stall_cnt(stall_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mdu_phase = 0;   // remaining cycles of an MDU sequence, the last one being the done cycle
    int stalls    = 0;   // unbounded count of stall cycles since reset

    typedef struct {
        logic [4:0]  r1, r2;
        logic        u1, u2;
        logic [4:0]  ers1, ers2, erd;
        logic        mread, redir;
        logic [4:0]  mrd, wrd;
        logic        mw, ww;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [10:0] pack(input logic pc, input logic ifid, input logic fl,
                                         input logic bub, input logic hold, input logic exmb,
                                         input logic [1:0] fa, input logic [1:0] fb,
                                         input logic done);
        return {pc, ifid, fl, bub, hold, exmb, fa, fb, done};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [10:0] ref_out();
        logic [1:0] fa, fb;
        logic lu;
        if (!rst) return 11'd0;
        fa = ref_fwd(ex_rs1);
        fb = ref_fwd(ex_rs2);
        lu = ex_mem_read && ex_rd != 5'd0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (mdu_phase == 1) return pack(1, 1, 0, 0, 0, 0, fa, fb, 1);
        if (mdu_phase > 1 || ex_mdu_op) return pack(0, 0, 0, 0, 1, 1, fa, fb, 0);
        if (ex_redirect) return pack(1, 1, 1, 1, 0, 0, fa, fb, 0);
        if (lu) return pack(0, 0, 0, 1, 0, 0, fa, fb, 0);
        return pack(1, 1, 0, 0, 0, 0, fa, fb, 0);
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negative edge: compare against the model, then advance the model on posedge.
    task automatic step(input string tag);
        logic [10:0] e;
        e = ref_out();
        chk({tag, " out"}, 32'(out1), 32'(e));
        chk({tag, " out_sat"}, 32'(out2), 32'(e));
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(sat(stalls, CNT_W)));
        chk({tag, " stall_cnt_sat"}, 32'(stall_cnt2), 32'(sat(stalls, CNT_W2)));
        @(posedge clk);
        if (rst) begin
            if (!e[10]) stalls++;
            if (mdu_phase > 1) mdu_phase--;
            else if (mdu_phase == 1) mdu_phase = 0;
            else if (ex_mdu_op) mdu_phase = MDU_LAT;
        end
        #1;
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        step(tag);
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_mdu_op = 1'b0;
        mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    endtask

    task automatic set_load_use();
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_rd = 5'd5; ex_mem_read = 1'b1;
    endtask

    initial begin
        int nz, nd, done_at, c0;
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, pack(1,1,0,0,0,0,2'b00,2'b00,0)};
        tbl[1]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd0,  5'd0,  5'd5, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, pack(0,0,0,1,0,0,2'b00,2'b00,0)};
        tbl[2]  = '{5'd6, 5'd1, 1'b1, 1'b1, 5'd5,  5'd1,  5'd6, 1'b0, 1'b0, 5'd5,  5'd0,  1'b1, 1'b0, pack(1,1,0,0,0,0,2'b10,2'b00,0)};
        tbl[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, pack(1,1,0,0,0,0,2'b00,2'b00,0)};
        tbl[4]  = '{5'd3, 5'd5, 1'b1, 1'b0, 5'd0,  5'd0,  5'd5, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, pack(1,1,0,0,0,0,2'b00,2'b00,0)};
        tbl[5]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd0,  5'd0,  5'd5, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, pack(0,0,0,1,0,0,2'b00,2'b00,0)};
        tbl[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd5, 1'b1, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0, pack(1,1,1,1,0,0,2'b00,2'b00,0)};
        tbl[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7,  5'd0,  5'd0, 1'b0, 1'b0, 5'd7,  5'd7,  1'b1, 1'b1, pack(1,1,0,0,0,0,2'b10,2'b00,0)};
        tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7,  5'd0,  5'd0, 1'b0, 1'b0, 5'd7,  5'd7,  1'b0, 1'b1, pack(1,1,0,0,0,0,2'b01,2'b00,0)};
        tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, pack(1,1,0,0,0,0,2'b00,2'b00,0)};
        tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd1,  5'd9,  5'd0, 1'b0, 1'b0, 5'd9,  5'd9,  1'b0, 1'b1, pack(1,1,0,0,0,0,2'b00,2'b01,0)};
        tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 5'd12, 5'd12, 1'b1, 1'b1, pack(1,1,0,0,0,0,2'b10,2'b10,0)};
        tbl[12] = '{5'd1, 5'd4, 1'b0, 1'b1, 5'd3,  5'd0,  5'd4, 1'b1, 1'b0, 5'd0,  5'd3,  1'b0, 1'b1, pack(0,0,0,1,0,0,2'b01,2'b00,0)};
        tbl[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  5'd8,  5'd0, 1'b0, 1'b1, 5'd8,  5'd0,  1'b1, 1'b0, pack(1,1,1,1,0,0,2'b00,2'b10,0)};

        rst = 1'b0;
        clear_inputs();
        #3;
        chk("reset out", 32'(out1), 32'd0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        repeat (2) cyc("reset");
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            id_rs1 = tbl[i].r1; id_rs2 = tbl[i].r2; id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2;
            ex_rs1 = tbl[i].ers1; ex_rs2 = tbl[i].ers2; ex_rd = tbl[i].erd;
            ex_mem_read = tbl[i].mread; ex_redirect = tbl[i].redir; ex_mdu_op = 1'b0;
            mem_rd = tbl[i].mrd; wb_rd = tbl[i].wrd;
            mem_reg_write = tbl[i].mw; wb_reg_write = tbl[i].ww;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(out1), 32'(tbl[i].exp));
            step($sformatf("vec%0d model", i));
        end
        clear_inputs();
        @(negedge clk);
        chk("table stall_cnt", 32'(stall_cnt), 32'd3);
        step("table end");

        // MDU op with a redirect and a load-use pending: both must be ignored.
        ex_mdu_op = 1'b1; ex_redirect = 1'b1; set_load_use();
        nz = 0; nd = 0; done_at = -1;
        @(negedge clk);
        c0 = int'(stall_cnt);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (!pc_write) nz++;
            if (mdu_done) begin nd++; done_at = i; end
            step("mdu");
        end
        clear_inputs();
        @(negedge clk);
        chk("mdu stall cycles", 32'(nz), 32'd4);
        chk("mdu done pulses", 32'(nd), 32'd1);
        chk("mdu done cycle", 32'(done_at), 32'd4);
        chk("mdu stall_cnt delta", 32'(int'(stall_cnt) - c0), 32'd4);
        chk("mdu no retrigger", 32'(pc_write), 32'd1);
        step("mdu after");

        // Reset during the second MDU_BUSY cycle abandons the op.
        ex_mdu_op = 1'b1;
        cyc("rst-mdu entry");
        cyc("rst-mdu busy1");
        #2;
        rst = 1'b0;
        mdu_phase = 0;
        stalls = 0;
        #1;
        chk("async reset out", 32'(out1), 32'd0);
        chk("async reset out_sat", 32'(out2), 32'd0);
        chk("async reset stall_cnt", 32'(stall_cnt), 32'd0);
        nd = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mdu_done) nd++;
            step("in reset");
        end
        rst = 1'b1;
        ex_mdu_op = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mdu_done) nd++;
            step("post reset");
        end
        chk("reset abandons mdu", 32'(nd), 32'd0);
        chk("post reset pc_write", 32'(pc_write), 32'd1);

        set_load_use();
        repeat (5) cyc("sat loaduse");
        clear_inputs();
        @(negedge clk);
        chk("sat stall_cnt 2b", 32'(stall_cnt2), 32'd3);
        chk("stall_cnt 16b after 5", 32'(stall_cnt), 32'd5);
        step("sat end");

        for (int i = 0; i < 3000; i++) begin
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
            ex_rd = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
            wb_rd = 5'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 5) == 0);
            ex_mdu_op = ($urandom_range(0, 11) == 0);
            mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
            cyc("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
